// File: rtl/lookup_cfg_writer.sv
// Control-stream writer for one stage's lookup engine: decodes header beats, assembles
// CAM key/mask or action words, and pulses the write strobes. Optional: LOOKUP_CFG_STAGE_FILTER_EN.
module lookup_cfg_writer #(
    parameter int STAGE   = 0,
    parameter int KEY_LEN = 197,
    parameter int ACT_LEN = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [KEY_LEN-1:0]     lookup_din,
    output logic [KEY_LEN-1:0]     lookup_din_mask,
    output logic [3:0]             lookup_din_addr,
    output logic                   lookup_din_en,
    output logic [ACT_LEN*25-1:0]  action_data_in,
    output logic [3:0]             action_addr,
    output logic                   action_en,
    output logic [15:0]            err_cnt
);

    localparam int ACT_W = ACT_LEN * 25;
    localparam int BUF_W = 640;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [3:0]       addr;
    logic             is_cam;
    logic             drain_next;
    logic [BUF_W-1:0] buffer;
    logic [BUF_W-1:0] buf_nxt;
    logic             accept;
    logic             op_ok;
    logic             stage_ok;
    logic             last_beat;
    logic             err_inc;
    logic             buf_unused;

    assign s_ready   = (state != WRITE);
    assign accept    = s_valid & s_ready;
    assign op_ok     = (s_data[63:60] == 4'h1) || (s_data[63:60] == 4'h2);
    assign last_beat = (cnt == (is_cam ? 4'd7 : 4'd9));

`ifdef LOOKUP_CFG_STAGE_FILTER_EN
    localparam logic [3:0] STAGE_ID = STAGE[3:0];
    assign stage_ok = (s_data[59:56] == STAGE_ID);
`else
    logic [3:0] stage_unused;
    assign stage_unused = STAGE[3:0] ^ s_data[59:56];
    assign stage_ok     = 1'b1;
`endif

    // The final beat goes straight from s_data into the output registers, so the
    // strobe lands the cycle after that beat rather than one cycle later.
    always_comb begin
        buf_nxt = buffer;
        buf_nxt[{cnt, 6'b0} +: 64] = s_data;
    end

    assign buf_unused = ^buf_nxt;

    always_comb begin
        err_inc = 1'b0;
        if (accept) begin
            case (state)
                IDLE:    err_inc = !op_ok || (stage_ok && s_last);
                COLLECT: err_inc = last_beat ? !s_last : s_last;
                default: err_inc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            addr            <= '0;
            is_cam          <= 1'b0;
            drain_next      <= 1'b0;
            buffer          <= '0;
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= '0;
            lookup_din_en   <= 1'b0;
            action_data_in  <= '0;
            action_addr     <= '0;
            action_en       <= 1'b0;
            err_cnt         <= '0;
        end else begin
            lookup_din_en <= 1'b0;
            action_en     <= 1'b0;
            if (err_inc && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!op_ok || !stage_ok) begin
                            state <= s_last ? IDLE : DRAIN;
                        end else if (!s_last) begin
                            state  <= COLLECT;
                            cnt    <= '0;
                            is_cam <= (s_data[63:60] == 4'h1);
                            addr   <= s_data[55:52];
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        buffer <= buf_nxt;
                        if (last_beat) begin
                            state      <= WRITE;
                            drain_next <= !s_last;
                            cnt        <= '0;
                            if (is_cam) begin
                                lookup_din      <= buf_nxt[KEY_LEN-1:0];
                                lookup_din_mask <= buf_nxt[256 +: KEY_LEN];
                                lookup_din_addr <= addr;
                                lookup_din_en   <= 1'b1;
                            end else begin
                                action_data_in  <= buf_nxt[ACT_W-1:0];
                                action_addr     <= addr;
                                action_en       <= 1'b1;
                            end
                        end else if (s_last) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    state <= drain_next ? DRAIN : IDLE;
                end
                default: begin
                    if (accept && s_last)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Randomized command-level bench for lookup_cfg_writer against a per-command outcome model.
module tb_lookup_cfg_writer;

    localparam int KEY_LEN = 197;
    localparam int ACT_W   = 625;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [KEY_LEN-1:0] lookup_din;
    logic [KEY_LEN-1:0] lookup_din_mask;
    logic [3:0]        lookup_din_addr;
    logic              lookup_din_en;
    logic [ACT_W-1:0]  action_data_in;
    logic [3:0]        action_addr;
    logic              action_en;
    logic [15:0]       err_cnt;

    lookup_cfg_writer #(.STAGE(0), .KEY_LEN(KEY_LEN), .ACT_LEN(25)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
        .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
        .action_data_in(action_data_in), .action_addr(action_addr),
        .action_en(action_en), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_cam;
        logic [3:0]   addr;
        logic [639:0] data;
        logic [639:0] mask;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;
    wr_t  obs[$];
    wr_t  exp_q[$];
    logic prev_en = 1'b0;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: records every write and checks handshake/strobe shape each cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            chk("s_ready_vs_strobe", 640'(s_ready), 640'(!(lookup_din_en || action_en)));
            chk("both_strobes", 640'(lookup_din_en & action_en), 640'(0));
            chk("strobe_one_cycle", 640'(prev_en & (lookup_din_en | action_en)), 640'(0));
            if (lookup_din_en)
                obs.push_back('{1'b1, lookup_din_addr, 640'(lookup_din), 640'(lookup_din_mask)});
            if (action_en)
                obs.push_back('{1'b0, action_addr, 640'(action_data_in), 640'(0)});
            prev_en = lookup_din_en | action_en;
        end
    end

    // Outcome of one whole command (header + payload up to s_last).
    task automatic model(input logic [63:0] b[$]);
        logic [3:0]   op;
        int           n;
        int           req;
        logic [639:0] raw;
        wr_t          w;
        op  = b[0][63:60];
        n   = b.size() - 1;
        req = (op == 4'h1) ? 8 : 10;
        if (op != 4'h1 && op != 4'h2) begin
            exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
            return;
        end
`ifdef LOOKUP_CFG_STAGE_FILTER_EN
        if (b[0][59:56] != 4'd0) return;
`endif
        if (n < req) begin
            exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
            return;
        end
        raw = '0;
        for (int i = 0; i < req; i++) raw[i*64 +: 64] = b[i+1];
        w.is_cam = (op == 4'h1);
        w.addr   = b[0][55:52];
        w.data   = '0;
        w.mask   = '0;
        if (w.is_cam) begin
            w.data[KEY_LEN-1:0] = raw[KEY_LEN-1:0];
            w.mask[KEY_LEN-1:0] = raw[256 +: KEY_LEN];
        end else begin
            w.data[ACT_W-1:0] = raw[ACT_W-1:0];
        end
        exp_q.push_back(w);
        if (n > req) exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
    endtask

    task automatic send(input logic [63:0] b[$], input int gap, input bit term);
        int w;
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            while ($urandom_range(0, 99) < gap) @(negedge clk);
            s_valid = 1'b1;
            s_data  = b[i];
            s_last  = term && (i == b.size() - 1);
            w = 0;
            while (!s_ready && w <= 20) begin
                @(negedge clk);
                w++;
            end
            if (w > 20) chk("ready_timeout", 640'(0), 640'(1));
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic compare_all();
        wr_t o, e;
        repeat (4) @(negedge clk);
        chk("write_count", 640'(obs.size()), 640'(exp_q.size()));
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            chk("wr_kind", 640'(o.is_cam), 640'(e.is_cam));
            chk("wr_addr", 640'(o.addr), 640'(e.addr));
            chk("wr_data", o.data, e.data);
            chk("wr_mask", o.mask, e.mask);
        end
        obs.delete();
        exp_q.delete();
        chk("err_cnt", 640'(err_cnt), 640'(exp_err));
    endtask

    task automatic run_cmd(input logic [63:0] b[$], input int gap);
        model(b);
        send(b, gap, 1'b1);
        compare_all();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic mk(input logic [3:0] op, input logic [3:0] stg, input logic [3:0] addr,
                      input int npay, output logic [63:0] b[$]);
        b = {};
        b.push_back({op, stg, addr, 52'(rnd64())});
        for (int i = 0; i < npay; i++) b.push_back(rnd64());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_din"}, 640'(lookup_din), 640'(0));
        chk({tag, "_mask"}, 640'(lookup_din_mask), 640'(0));
        chk({tag, "_caddr"}, 640'(lookup_din_addr), 640'(0));
        chk({tag, "_cen"}, 640'(lookup_din_en), 640'(0));
        chk({tag, "_act"}, 640'(action_data_in), 640'(0));
        chk({tag, "_aaddr"}, 640'(action_addr), 640'(0));
        chk({tag, "_aen"}, 640'(action_en), 640'(0));
        chk({tag, "_err"}, 640'(err_cnt), 640'(0));
        chk({tag, "_ready"}, 640'(s_ready), 640'(1));
    endtask

    initial begin
        logic [63:0]  b[$];
        logic [639:0] ones;
        int           kind, op, npay, req;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // CAM write, addr 5, incrementing key, all-ones mask
        b = {};
        b.push_back({4'h1, 4'h0, 4'h5, 52'h0});
        for (int i = 0; i < 4; i++) b.push_back(64'(i + 1) * 64'h0101_0101_0101_0101);
        for (int i = 0; i < 4; i++) b.push_back('1);
        run_cmd(b, 0);
        ones = '0;
        ones[KEY_LEN-1:0] = '1;
        chk("cam_addr5", 640'(lookup_din_addr), 640'(5));
        chk("cam_mask_ones", 640'(lookup_din_mask), ones);

        // Action write to addr 15
        mk(4'h2, 4'h0, 4'hF, 10, b);
        run_cmd(b, 30);
        chk("act_addr15", 640'(action_addr), 640'(15));

        // Short action command, then immediately a good one
        mk(4'h2, 4'h0, 4'h3, 4, b);
        run_cmd(b, 0);
        mk(4'h1, 4'h0, 4'h9, 8, b);
        run_cmd(b, 0);

        // Overlength CAM, stage mismatch, unknown opcode
        mk(4'h1, 4'h0, 4'h2, 10, b);
        run_cmd(b, 20);
        mk(4'h1, 4'h3, 4'h4, 8, b);
        run_cmd(b, 0);
        mk(4'h7, 4'h0, 4'h1, 3, b);
        run_cmd(b, 0);

        // Reset in the middle of a CAM command with gaps
        mk(4'h1, 4'h0, 4'h6, 3, b);
        send(b, 50, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        obs.delete();
        exp_q.delete();
        check_reset_outputs("midrst");
        mk(4'h1, 4'h0, 4'hC, 8, b);
        run_cmd(b, 10);

        // Random mix of well-formed and malformed commands
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 5);
            op   = $urandom_range(1, 2);
            req  = (op == 1) ? 8 : 10;
            case (kind)
                0, 1:    npay = req;
                2:       npay = $urandom_range(1, req - 1);
                3:       npay = req + $urandom_range(1, 3);
                4: begin
                    op   = $urandom_range(3, 15);
                    npay = $urandom_range(0, 4);
                end
                default: npay = 0;
            endcase
            mk(4'(op), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), npay, b);
            run_cmd(b, $urandom_range(0, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
